// File: rtl/mcpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit, datapath muxes and ALU controller.
package mcpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXR    = 4'd6,
      S_WBR    = 4'd7,
      S_EXI    = 4'd8,
      S_WBI    = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_TRAP   = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_4      = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_ce;
      logic       ir_ce;
      logic       mdr_ce;
      logic       mem_rd;
      logic       mem_wr;
      logic       iord;
      logic       reg_we;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal;
   } ctrl_t;

   // States in which the FSM may stall on mem_ready and the timeout counter runs.
   function automatic logic is_wait_state(input state_e st);
      return (st == S_IF) || (st == S_MEMRD) || (st == S_MEMWR);
   endfunction

endpackage

// File: rtl/mcpu_ctrl_decode.sv
// Combinational control decode: current state, opcode, ALU zero and memory completion -> control word.
module mcpu_ctrl_decode
   import mcpu_ctrl_pkg::*;
(
   input  state_e     i_state,
   input  logic [5:0] i_opcode,
   input  logic       i_zero,
   input  logic       i_mem_done,
   output ctrl_t      o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_IF: begin
            o_ctrl.mem_rd    = 1'b1;
            o_ctrl.alu_src_b = SRCB_4;
            o_ctrl.ir_ce     = i_mem_done;
            o_ctrl.pc_ce     = i_mem_done;
         end
         S_ID: begin
            o_ctrl.alu_src_b = SRCB_IMM_SH;
         end
         S_MEMADR, S_EXI: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            o_ctrl.mem_rd = 1'b1;
            o_ctrl.iord   = 1'b1;
            o_ctrl.mdr_ce = i_mem_done;
         end
         S_MEMWB: begin
            o_ctrl.reg_we     = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            o_ctrl.mem_wr = 1'b1;
            o_ctrl.iord   = 1'b1;
         end
         S_EXR: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_WBR: begin
            o_ctrl.reg_we  = 1'b1;
            o_ctrl.reg_dst = 1'b1;
         end
         S_WBI: begin
            o_ctrl.reg_we = 1'b1;
         end
         S_BRANCH: begin
            // Only beq/bne reach BRANCH, so anything that is not beq is bne.
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_op    = ALUOP_SUB;
            o_ctrl.pc_src    = PCSRC_ALUOUT;
            o_ctrl.pc_ce     = (i_opcode == OP_BEQ) ? i_zero : ~i_zero;
         end
         S_JUMP: begin
            o_ctrl.pc_src = PCSRC_JUMP;
            o_ctrl.pc_ce  = 1'b1;
         end
         S_TRAP: begin
            o_ctrl.illegal = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: IF/ID/EX/MEM/WB sequencing, stalls on mem_ready, traps on timeout.
// Latency with zero-wait memory: R/addi/sw 4, lw 5, beq/bne/j 3 cycles.
module mcpu_ctrl_fsm
   import mcpu_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int STATE_W     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_ce,
   output logic               ir_ce,
   output logic               mdr_ce,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic               iord,
   output logic               reg_we,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         pc_src,
   output logic [STATE_W-1:0] state,
   output logic               illegal
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   state_e           r_state;
   state_e           w_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_wait;
   logic             w_timeout;
   logic             w_mem_done;
   ctrl_t            w_ctrl;
   logic             w_unused_funct;

   // funct is consumed by the ALU controller, not by the sequencer.
   assign w_unused_funct = ^funct;

   assign w_wait     = is_wait_state(r_state);
   assign w_timeout  = (MEM_TIMEOUT != 0) && w_wait && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
   assign w_mem_done = mem_ready & ~w_timeout;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IF;
      end else begin
         r_state <= w_nxt;
      end
   end

   // Counts consecutive stalled cycles within one wait state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if ((MEM_TIMEOUT == 0) || !w_wait || mem_ready || (w_nxt != r_state)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IF:     w_nxt = w_timeout ? S_TRAP : (mem_ready ? S_ID : S_IF);
         S_ID: begin
            case (opcode)
               OP_LW, OP_SW:   w_nxt = S_MEMADR;
               OP_RTYPE:       w_nxt = S_EXR;
               OP_ADDI:        w_nxt = S_EXI;
               OP_BEQ, OP_BNE: w_nxt = S_BRANCH;
               OP_J:           w_nxt = S_JUMP;
               default:        w_nxt = S_TRAP;
            endcase
         end
         S_MEMADR: w_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_nxt = w_timeout ? S_TRAP : (mem_ready ? S_MEMWB : S_MEMRD);
         S_MEMWR:  w_nxt = w_timeout ? S_TRAP : (mem_ready ? S_IF : S_MEMWR);
         S_EXR:    w_nxt = S_WBR;
         S_EXI:    w_nxt = S_WBI;
         S_MEMWB, S_WBR, S_WBI, S_BRANCH, S_JUMP: w_nxt = S_IF;
         S_TRAP:   w_nxt = S_TRAP;
         default:  w_nxt = S_TRAP;
      endcase
   end

   mcpu_ctrl_decode u_decode (
      .i_state    (r_state),
      .i_opcode   (opcode),
      .i_zero     (zero),
      .i_mem_done (w_mem_done),
      .o_ctrl     (w_ctrl)
   );

   // Reset gates every output combinationally so an in-flight access drops at once.
   always_comb begin
      pc_ce      = 1'b0;
      ir_ce      = 1'b0;
      mdr_ce     = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      iord       = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      state      = '0;
      illegal    = 1'b0;
      if (rst) begin
         pc_ce      = w_ctrl.pc_ce;
         ir_ce      = w_ctrl.ir_ce;
         mdr_ce     = w_ctrl.mdr_ce;
         mem_rd     = w_ctrl.mem_rd;
         mem_wr     = w_ctrl.mem_wr;
         iord       = w_ctrl.iord;
         reg_we     = w_ctrl.reg_we;
         reg_dst    = w_ctrl.reg_dst;
         mem_to_reg = w_ctrl.mem_to_reg;
         alu_src_a  = w_ctrl.alu_src_a;
         alu_src_b  = w_ctrl.alu_src_b;
         alu_op     = w_ctrl.alu_op;
         pc_src     = w_ctrl.pc_src;
         state      = STATE_W'(r_state);
         illegal    = w_ctrl.illegal;
      end
   end

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Self-checking bench for mcpu_ctrl_fsm: per-cycle scoreboard on the main instance, timeout on a second instance.
module tb_mcpu_ctrl_fsm;
   import mcpu_ctrl_pkg::*;

   logic       clk;
   logic       rst;
   logic       rst_to;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       rdy_to;

   logic       pc_ce, ir_ce, mdr_ce, mem_rd, mem_wr, iord, reg_we, reg_dst, mem_to_reg, alu_src_a, illegal;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic [3:0] state;

   logic       t_pc_ce, t_ir_ce, t_mdr_ce, t_mem_rd, t_mem_wr, t_iord, t_reg_we, t_reg_dst, t_mem_to_reg;
   logic       t_alu_src_a, t_illegal;
   logic [1:0] t_alu_src_b, t_alu_op, t_pc_src;
   logic [3:0] state_to;

   logic [16:0] obs, obs_to;

   typedef struct packed {
      logic [3:0]  st;
      logic [16:0] ctl;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   mcpu_ctrl_fsm #(.MEM_TIMEOUT(16), .STATE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pc_ce(pc_ce), .ir_ce(ir_ce), .mdr_ce(mdr_ce), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord),
      .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .state(state), .illegal(illegal)
   );

   mcpu_ctrl_fsm #(.MEM_TIMEOUT(4), .STATE_W(4)) dut_to (
      .clk(clk), .rst(rst_to), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(rdy_to),
      .pc_ce(t_pc_ce), .ir_ce(t_ir_ce), .mdr_ce(t_mdr_ce), .mem_rd(t_mem_rd), .mem_wr(t_mem_wr),
      .iord(t_iord), .reg_we(t_reg_we), .reg_dst(t_reg_dst), .mem_to_reg(t_mem_to_reg),
      .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b), .alu_op(t_alu_op), .pc_src(t_pc_src),
      .state(state_to), .illegal(t_illegal)
   );

   assign obs    = {pc_ce, ir_ce, mdr_ce, mem_rd, mem_wr, iord, reg_we, reg_dst, mem_to_reg,
                    alu_src_a, alu_src_b, alu_op, pc_src, illegal};
   assign obs_to = {t_pc_ce, t_ir_ce, t_mdr_ce, t_mem_rd, t_mem_wr, t_iord, t_reg_we, t_reg_dst,
                    t_mem_to_reg, t_alu_src_a, t_alu_src_b, t_alu_op, t_pc_src, t_illegal};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Expected control word per state, straight from the state table; ce bits supplied by the caller.
   function automatic logic [16:0] ex(input state_e st, input logic pc, input logic ir, input logic mdr);
      logic [16:0] v;
      v = '0;
      v[16] = pc;
      v[15] = ir;
      v[14] = mdr;
      case (st)
         S_IF:     begin v[13] = 1'b1; v[6:5] = 2'b01; end
         S_ID:     v[6:5] = 2'b11;
         S_MEMADR: begin v[7] = 1'b1; v[6:5] = 2'b10; end
         S_MEMRD:  begin v[13] = 1'b1; v[11] = 1'b1; end
         S_MEMWB:  begin v[10] = 1'b1; v[8] = 1'b1; end
         S_MEMWR:  begin v[12] = 1'b1; v[11] = 1'b1; end
         S_EXR:    begin v[7] = 1'b1; v[4:3] = 2'b10; end
         S_WBR:    begin v[10] = 1'b1; v[9] = 1'b1; end
         S_EXI:    begin v[7] = 1'b1; v[6:5] = 2'b10; end
         S_WBI:    v[10] = 1'b1;
         S_BRANCH: begin v[7] = 1'b1; v[4:3] = 2'b01; v[2:1] = 2'b01; end
         S_JUMP:   v[2:1] = 2'b10;
         S_TRAP:   v[0] = 1'b1;
         default:  ;
      endcase
      return v;
   endfunction

   task automatic mon_cmp();
      exp_t e;
      e = sb_q.pop_front();
      check("state", {28'd0, state}, {28'd0, e.st});
      check("ctrl", {15'd0, obs}, {15'd0, e.ctl});
      check("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
      check("ce_excl", {31'd0, (ir_ce & mdr_ce) | (ir_ce & reg_we) | (mdr_ce & reg_we)}, 32'd0);
   endtask

   // Called at a falling edge: drive this cycle's inputs, queue the expectation, sample mid-cycle.
   task automatic cyc(input logic rdy, input logic z, input state_e st, input logic [16:0] ctl);
      exp_t e;
      mem_ready = rdy;
      zero      = z;
      e.st      = st;
      e.ctl     = ctl;
      sb_q.push_back(e);
      #2;
      mon_cmp();
      @(negedge clk);
   endtask

   initial begin
      exp_t e;
      rst = 1'b0; rst_to = 1'b0; rdy_to = 1'b0;
      opcode = OP_LW; funct = FN_ADD; zero = 1'b0; mem_ready = 1'b1;

      // Reset: everything 0 even though mem_ready is high.
      @(negedge clk);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, S_IF, 17'd0);
      rst = 1'b1;

      opcode = OP_RTYPE;
      cyc(1'b1, 1'b0, S_IF,  ex(S_IF, 1'b1, 1'b1, 1'b0));
      cyc(1'b1, 1'b0, S_ID,  ex(S_ID, 1'b0, 1'b0, 1'b0));
      cyc(1'b1, 1'b0, S_EXR, ex(S_EXR, 1'b0, 1'b0, 1'b0));
      cyc(1'b1, 1'b0, S_WBR, ex(S_WBR, 1'b0, 1'b0, 1'b0));

      opcode = OP_LW;
      cyc(1'b1, 1'b0, S_IF,     ex(S_IF, 1'b1, 1'b1, 1'b0));
      cyc(1'b1, 1'b0, S_ID,     ex(S_ID, 1'b0, 1'b0, 1'b0));
      cyc(1'b1, 1'b0, S_MEMADR, ex(S_MEMADR, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, S_MEMRD, ex(S_MEMRD, 1'b0, 1'b0, 1'b0));
      cyc(1'b1, 1'b0, S_MEMRD,  ex(S_MEMRD, 1'b0, 1'b0, 1'b1));
      cyc(1'b1, 1'b0, S_MEMWB,  ex(S_MEMWB, 1'b0, 1'b0, 1'b0));

      opcode = OP_SW;
      cyc(1'b0, 1'b0, S_IF,     ex(S_IF, 1'b0, 1'b0, 1'b0));
      cyc(1'b0, 1'b0, S_IF,     ex(S_IF, 1'b0, 1'b0, 1'b0));
      cyc(1'b1, 1'b0, S_IF,     ex(S_IF, 1'b1, 1'b1, 1'b0));
      cyc(1'b0, 1'b0, S_ID,     ex(S_ID, 1'b0, 1'b0, 1'b0));
      cyc(1'b0, 1'b0, S_MEMADR, ex(S_MEMADR, 1'b0, 1'b0, 1'b0));
      cyc(1'b1, 1'b0, S_MEMWR,  ex(S_MEMWR, 1'b0, 1'b0, 1'b0));

      opcode = OP_ADDI;
      cyc(1'b1, 1'b0, S_IF,  ex(S_IF, 1'b1, 1'b1, 1'b0));
      cyc(1'b1, 1'b0, S_ID,  ex(S_ID, 1'b0, 1'b0, 1'b0));
      cyc(1'b1, 1'b0, S_EXI, ex(S_EXI, 1'b0, 1'b0, 1'b0));
      cyc(1'b1, 1'b0, S_WBI, ex(S_WBI, 1'b0, 1'b0, 1'b0));

      // Branch table: {opcode, zero, expected pc_ce}.
      for (int b = 0; b < 4; b++) begin
         logic bz, bpc;
         opcode = (b < 2) ? OP_BEQ : OP_BNE;
         bz     = b[0];
         bpc    = (b < 2) ? bz : ~bz;
         cyc(1'b1, bz, S_IF,     ex(S_IF, 1'b1, 1'b1, 1'b0));
         cyc(1'b1, bz, S_ID,     ex(S_ID, 1'b0, 1'b0, 1'b0));
         cyc(1'b1, bz, S_BRANCH, ex(S_BRANCH, bpc, 1'b0, 1'b0));
      end

      opcode = OP_J;
      cyc(1'b1, 1'b0, S_IF,   ex(S_IF, 1'b1, 1'b1, 1'b0));
      cyc(1'b1, 1'b0, S_ID,   ex(S_ID, 1'b0, 1'b0, 1'b0));
      cyc(1'b1, 1'b0, S_JUMP, ex(S_JUMP, 1'b1, 1'b0, 1'b0));

      opcode = 6'b111111;
      cyc(1'b1, 1'b0, S_IF, ex(S_IF, 1'b1, 1'b1, 1'b0));
      cyc(1'b1, 1'b0, S_ID, ex(S_ID, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 20; i++)
         cyc(1'($urandom_range(1)), 1'($urandom_range(1)), S_TRAP, ex(S_TRAP, 1'b0, 1'b0, 1'b0));

      // Reset out of TRAP, then reset again in the middle of a store.
      rst = 1'b0;
      cyc(1'b1, 1'b0, S_IF, 17'd0);
      rst = 1'b1;
      opcode = OP_SW;
      cyc(1'b1, 1'b0, S_IF,     ex(S_IF, 1'b1, 1'b1, 1'b0));
      cyc(1'b1, 1'b0, S_ID,     ex(S_ID, 1'b0, 1'b0, 1'b0));
      cyc(1'b1, 1'b0, S_MEMADR, ex(S_MEMADR, 1'b0, 1'b0, 1'b0));
      mem_ready = 1'b0;
      e.st = S_MEMWR; e.ctl = ex(S_MEMWR, 1'b0, 1'b0, 1'b0);
      sb_q.push_back(e);
      #2;
      mon_cmp();
      rst  = 1'b0;
      e.st = S_IF; e.ctl = 17'd0;
      sb_q.push_back(e);
      #1;
      mon_cmp();
      @(negedge clk);
      cyc(1'b1, 1'b0, S_IF, 17'd0);
      rst = 1'b1;
      cyc(1'b1, 1'b0, S_IF, ex(S_IF, 1'b1, 1'b1, 1'b0));

      // Timeout instance (limit 4): ready on the 3rd IF cycle still fetches.
      opcode = OP_RTYPE;
      rst_to = 1'b1;
      rdy_to = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #2; check("to_wait_if", {28'd0, state_to}, {28'd0, S_IF}); @(negedge clk);
      end
      rdy_to = 1'b1;
      #2; check("to_late_irce", {31'd0, t_ir_ce}, 32'd1); @(negedge clk);
      rdy_to = 1'b0;
      #2; check("to_late_id", {28'd0, state_to}, {28'd0, S_ID}); @(negedge clk);

      // No ready at all: TRAP follows the 4th wait cycle.
      rst_to = 1'b0; @(negedge clk); rst_to = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2; check("to_hold_if", {28'd0, state_to}, {28'd0, S_IF}); @(negedge clk);
      end
      #2;
      check("to_trap", {28'd0, state_to}, {28'd0, S_TRAP});
      check("to_illegal", {15'd0, obs_to}, {15'd0, ex(S_TRAP, 1'b0, 1'b0, 1'b0)});
      @(negedge clk);

      // Ready coinciding with the 4th wait cycle loses to the timeout.
      rst_to = 1'b0; @(negedge clk); rst_to = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2; check("to_pri_if", {28'd0, state_to}, {28'd0, S_IF}); @(negedge clk);
      end
      rdy_to = 1'b1;
      #2; check("to_pri_noce", {30'd0, t_ir_ce, t_pc_ce}, 32'd0); @(negedge clk);
      #2; check("to_pri_trap", {28'd0, state_to}, {28'd0, S_TRAP}); @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
